// File: rtl/mult_err_acc_if.sv
// Sample bus between the multiplier-issue side and the error-statistics stage.
// Latency: none, wires only; p_approx belongs to the sample driven LAT cycles earlier.
// Backpressure: none; the consumer must accept every sample while it is running.
// Signals: in_valid (sample strobe), x/y (operands as sent to the multiplier),
//          p_approx (approximate product returned by the multiplier).
interface mult_err_acc_if #(
    parameter int W = 16
) ();
    logic             in_valid;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [2*W-1:0]   p_approx;

    modport master (output in_valid, output x, output y, output p_approx);
    modport slave  (input  in_valid, input  x, input  y, input  p_approx);
endinterface

// File: rtl/mult_err_acc.sv
// Purpose: error statistics (sum/max of |exact-approx|, error and over-estimate counts)
//          for an approximate multiplier, over a run of n_samples operand pairs.
// Latency: a sample is accumulated LAT cycles after it is accepted; done one edge after the last.
// Backpressure: none; samples are taken whenever in_valid is high in RUN, ignored otherwise.
// Ports: clk, rst (async active-high), start, n_samples, smp (in_valid/x/y/p_approx),
//        busy, done, sample_cnt, sum_ed, max_ed, err_cnt, over_cnt.
module mult_err_acc #(
    parameter int W     = 16,
    parameter int LAT   = 2,
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    mult_err_acc_if.slave        smp,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [2*W-1:0]       max_ed,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     over_cnt
);
    localparam int PW = 2 * W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;

    logic [CNT_W-1:0]    n_lat;
    logic [CNT_W-1:0]    issue_cnt;
    logic [LAT-1:0]      vld_pipe;
    logic [PW-1:0]       exact_pipe [LAT];

    logic                start_ok;
    logic                accept;
    logic                last_issue;
    logic                cmp_vld;
    logic                last_cmp;
    logic [PW-1:0]       exact_now;
    logic [PW-1:0]       cmp_exact;
    logic                over;
    logic [PW-1:0]       ed;
    logic [ACC_W:0]      sum_add;
    logic [ACC_W-1:0]    sum_nxt;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign accept     = (state == RUN) && smp.in_valid;
    // n_lat >= 1 whenever we are in RUN, so n_lat-1 never underflows here
    assign last_issue = accept && (issue_cnt == n_lat - CNT_ONE);
    assign cmp_vld    = vld_pipe[LAT-1] && (state == RUN || state == DRAIN);
    assign last_cmp   = cmp_vld && (sample_cnt == n_lat - CNT_ONE);

    assign exact_now  = PW'(smp.x) * PW'(smp.y);
    assign cmp_exact  = exact_pipe[LAT-1];
    assign over       = smp.p_approx > cmp_exact;
    assign ed         = over ? (smp.p_approx - cmp_exact) : (cmp_exact - smp.p_approx);

    // One extra bit catches the carry; once at all-ones any non-zero ed carries
    // again, so the clamp also holds the saturated value.
    assign sum_add    = {1'b0, sum_ed} + (ACC_W+1)'(ed);
    assign sum_nxt    = sum_add[ACC_W] ? {ACC_W{1'b1}} : sum_add[ACC_W-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_cmp) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default: ;
        endcase
    end

    // Exact-product pipe, aligned with the multiplier's own latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                exact_pipe[i] <= '0;
            end
        end else begin
            if (start_ok) begin
                vld_pipe <= '0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                end
                vld_pipe[0] <= accept;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                exact_pipe[i] <= exact_pipe[i-1];
            end
            exact_pipe[0] <= exact_now;
        end
    end

    // Run length and issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat     <= '0;
            issue_cnt <= '0;
        end else if (start_ok) begin
            n_lat     <= n_samples;
            issue_cnt <= '0;
        end else if (accept) begin
            issue_cnt <= issue_cnt + CNT_ONE;
        end
    end

    // Statistics accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
        end else if (cmp_vld) begin
            sample_cnt <= sample_cnt + CNT_ONE;
            sum_ed     <= sum_nxt;
            if (ed > max_ed) begin
                max_ed <= ed;
            end
            if (ed != '0) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            if (over) begin
                over_cnt <= over_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_mult_err_acc.sv
// Bench for mult_err_acc: randomized and directed runs, expected statistics pushed
// into a queue at run issue and compared by a monitor when done asserts.
module tb_mult_err_acc;
    localparam int W   = 16;
    localparam int LAT = 2;

    typedef struct {
        logic [63:0] cnt;
        logic [63:0] sum;
        logic [63:0] mx;
        logic [63:0] err;
        logic [63:0] ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [31:0] n_samples, n2;
    logic        busy, done, busy2, done2;
    logic [31:0] sample_cnt, err_cnt, over_cnt, sample_cnt2, err_cnt2, over_cnt2;
    logic [47:0] sum_ed;
    logic [31:0] sum_ed2;
    logic [31:0] max_ed, max_ed2;

    logic [31:0] approx_src;
    logic [31:0] apipe [LAT];

    int errors = 0;
    int checks = 0;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic        done_prev = 1'b0;
    logic        start_prev = 1'b0;

    logic [15:0] gx [$];
    logic [15:0] gy [$];
    logic [31:0] gp [$];

    mult_err_acc_if #(.W(W)) sif ();

    mult_err_acc #(.W(W), .LAT(LAT), .ACC_W(48), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .smp(sif.slave),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .err_cnt(err_cnt), .over_cnt(over_cnt)
    );

    mult_err_acc #(.W(W), .LAT(LAT), .ACC_W(32), .CNT_W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start2), .n_samples(n2), .smp(sif.slave),
        .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .sum_ed(sum_ed2),
        .max_ed(max_ed2), .err_cnt(err_cnt2), .over_cnt(over_cnt2)
    );

    always #5 clk = ~clk;

    // Stand-in for the multiplier's LAT-cycle output delay
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) apipe[i] <= apipe[i-1];
        apipe[0] <= approx_src;
    end
    assign sif.p_approx = apipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the finished run's statistics when done rises
    // (or re-asserts right after a start, as a zero-length run from DONE does)
    always @(negedge clk) begin
        if (!rst && done && (!done_prev || start_prev)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample_cnt", 64'(sample_cnt), mon_e.cnt);
                chk("sum_ed",     64'(sum_ed),     mon_e.sum);
                chk("max_ed",     64'(max_ed),     mon_e.mx);
                chk("err_cnt",    64'(err_cnt),    mon_e.err);
                chk("over_cnt",   64'(over_cnt),   mon_e.ovr);
            end
        end
        done_prev  = done;
        start_prev = start;
    end

    task automatic add_sample(input logic [15:0] xa, input logic [15:0] ya, input logic [31:0] pa);
        gx.push_back(xa);
        gy.push_back(ya);
        gp.push_back(pa);
    endtask

    task automatic add_random(input int n);
        logic [15:0] xa, ya;
        longint      e, p, d;
        for (int i = 0; i < n; i++) begin
            xa = 16'($urandom);
            ya = 16'($urandom);
            e  = longint'(xa) * longint'(ya);
            case ($urandom_range(0, 3))
                0: p = e;
                1: begin
                    p = e + longint'($urandom_range(1, 5000));
                    if (p > 64'hFFFF_FFFF) p = e;
                end
                2: begin
                    d = longint'($urandom_range(1, 5000));
                    p = (e >= d) ? e - d : e;
                end
                default: p = longint'($urandom);
            endcase
            add_sample(xa, ya, 32'(p));
        end
    endtask

    task automatic drive_sample(input logic [15:0] xa, input logic [15:0] ya, input logic [31:0] pa);
        sif.in_valid = 1'b1;
        sif.x        = xa;
        sif.y        = ya;
        approx_src   = pa;
        tick();
        sif.in_valid = 1'b0;
        approx_src   = 32'($urandom);
    endtask

    // Runs the samples queued in gx/gy/gp; the reference result is computed
    // from the samples with plain arithmetic and pushed before the run starts.
    task automatic do_run(input bit gaps, input bit stray);
        int      n;
        int      b;
        longint  e, p, ed;
        longint  sum, mx, err, ovr;
        exp_t    ex;
        n = gx.size();
        sum = 0; mx = 0; err = 0; ovr = 0;
        for (int i = 0; i < n; i++) begin
            e  = longint'(gx[i]) * longint'(gy[i]);
            p  = longint'(gp[i]);
            ed = (e >= p) ? e - p : p - e;
            sum = sum + ed;
            if (sum > 64'hFFFF_FFFF_FFFF) sum = 64'hFFFF_FFFF_FFFF;
            if (ed > mx) mx = ed;
            if (ed != 0) err++;
            if (p > e) ovr++;
        end
        ex.cnt = 64'(n); ex.sum = 64'(sum); ex.mx = 64'(mx); ex.err = 64'(err); ex.ovr = 64'(ovr);
        exp_q.push_back(ex);

        if (stray) begin
            repeat (2) drive_sample(16'($urandom), 16'($urandom), 32'($urandom));
        end
        start = 1'b1;
        n_samples = 32'(n);
        tick();
        start = 1'b0;
        if (n == 0) chk("busy_n0", 64'(busy), 64'd0);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (stray && i == 1) begin
                start = 1'b1;
                n_samples = 32'd1;
                tick();
                start = 1'b0;
                n_samples = 32'(n);
            end
            drive_sample(gx[i], gy[i], gp[i]);
        end
        if (stray) drive_sample(16'($urandom), 16'($urandom), 32'($urandom));
        b = 0;
        while (!done && b < 200) begin
            tick();
            b++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done within 200 cycles");
        end
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        if (stray) begin
            repeat (2) drive_sample(16'($urandom), 16'($urandom), 32'($urandom));
            repeat (3) tick();
            chk("held_sample_cnt", 64'(sample_cnt), 64'(n));
            chk("held_sum_ed", 64'(sum_ed), 64'(sum));
            chk("held_done", 64'(done), 64'd1);
        end
        gx.delete(); gy.delete(); gp.delete();
    endtask

    initial begin
        int b;
        rst = 1'b1;
        start = 1'b0; start2 = 1'b0;
        n_samples = '0; n2 = '0;
        sif.in_valid = 1'b0; sif.x = '0; sif.y = '0;
        approx_src = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_sum_ed", 64'(sum_ed), 64'd0);
        chk("rst_max_ed", 64'(max_ed), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_over_cnt", 64'(over_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // n=1 exact match
        add_sample(16'd3, 16'd5, 32'd15);
        do_run(1'b0, 1'b0);

        // n=3 mixed errors, plus fixed expectations
        add_sample(16'd100, 16'd100, 32'd9984);
        add_sample(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        add_sample(16'd7, 16'd9, 32'd64);
        do_run(1'b0, 1'b0);
        chk("t2_sum_ed", 64'(sum_ed), 64'd17);
        chk("t2_max_ed", 64'(max_ed), 64'd16);
        chk("t2_err_cnt", 64'(err_cnt), 64'd2);
        chk("t2_over_cnt", 64'(over_cnt), 64'd1);

        // n=0 from DONE with non-zero stats: clears and completes at once
        do_run(1'b0, 1'b0);
        chk("t3_done", 64'(done), 64'd1);

        // n=4 with gaps and stray pulses
        add_random(4);
        do_run(1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            add_random($urandom_range(1, 12));
            do_run(1'b1, r[0]);
        end

        // 32-bit accumulator saturation
        start2 = 1'b1;
        n2 = 32'd2;
        tick();
        start2 = 1'b0;
        drive_sample(16'hFFFF, 16'hFFFF, 32'h0FFE0001);
        drive_sample(16'hFFFF, 16'hFFFF, 32'h0FFE0001);
        b = 0;
        while (!done2 && b < 50) begin
            tick();
            b++;
        end
        chk("sat_done", 64'(done2), 64'd1);
        chk("sat_sum_ed", 64'(sum_ed2), 64'hFFFF_FFFF);
        chk("sat_max_ed", 64'(max_ed2), 64'hF000_0000);
        chk("sat_err_cnt", 64'(err_cnt2), 64'd2);
        chk("sat_over_cnt", 64'(over_cnt2), 64'd0);
        chk("sat_sample_cnt", 64'(sample_cnt2), 64'd2);
        repeat (4) tick();
        chk("sat_held", 64'(sum_ed2), 64'hFFFF_FFFF);

        // Reset in the middle of an n=8 run
        start = 1'b1;
        n_samples = 32'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) drive_sample(16'd1000, 16'd3, 32'd2000);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("arst_sum_ed", 64'(sum_ed), 64'd0);
        chk("arst_max_ed", 64'(max_ed), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        add_random(1);
        do_run(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
